// File: rtl/wb_daq_data_disaggregation.sv
// Playback disaggregator: pops 32-bit FIFO words and streams 8/16/32-bit slices to the DAC.
// Optional underrun monitor is compiled in with `define WB_DAQ_DISAGG_UNDERRUN_EN.
module wb_daq_data_disaggregation #(
  parameter int dw     = 32,
  parameter int dac_dw = 32
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              enable,
  input  logic [1:0]        data_width,
  input  logic              fifo_empty,
  input  logic [dw-1:0]     fifo_data,
  output logic              fifo_pop,
  output logic [dac_dw-1:0] dac_data_out,
  output logic              dac_valid,
  input  logic              dac_ready,
  output logic              busy,
  input  logic              underrun_clr,
  output logic              underrun_flag,
  output logic [15:0]       underrun_count
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t        state;
  logic [dw-1:0] word_q;
  logic [1:0]    idx_q;
  logic [1:0]    width_q;
  logic          can_pop, xfer, last;
  logic [31:0]   slice;

  assign can_pop = enable & ~fifo_empty;
  assign xfer    = dac_valid & dac_ready;
  assign busy    = (state != IDLE);

  // width 3 behaves as 32-bit, so bit 1 alone selects the full word
  always_comb begin
    last = 1'b1;
    if (!width_q[1]) last = width_q[0] ? idx_q[0] : &idx_q;
  end

  always_comb begin
    slice = '0;
    if (width_q[1])      slice        = word_q[31:0];
    else if (width_q[0]) slice[15:0]  = word_q[{idx_q[0], 4'd0} +: 16];
    else                 slice[7:0]   = word_q[{idx_q, 3'd0} +: 8];
  end

  assign dac_data_out = dac_dw'(slice);

  // Pop is combinational so the refill can ride on the last-slice transfer,
  // leaving only the FETCH cycle as the inter-word bubble.
  assign fifo_pop = wb_rst & can_pop &
                    ((state == IDLE) | ((state == SEND) & xfer & last));

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state     <= IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      width_q   <= '0;
      dac_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (can_pop) state <= FETCH;
        FETCH: begin
          word_q    <= fifo_data;
          width_q   <= data_width;
          idx_q     <= '0;
          dac_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (xfer) begin
          if (last) begin
            dac_valid <= 1'b0;
            state     <= can_pop ? FETCH : IDLE;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_DAQ_DISAGG_UNDERRUN_EN
  logic delivered;
  logic urun;

  assign urun = dac_ready & ~dac_valid & enable & delivered;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      delivered      <= 1'b0;
      underrun_flag  <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (!enable)   delivered <= 1'b0;
      else if (xfer) delivered <= 1'b1;
      if (underrun_clr) begin
        underrun_flag  <= 1'b0;
        underrun_count <= '0;
      end else if (urun) begin
        underrun_flag <= 1'b1;
        if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr     = underrun_clr;
  assign underrun_flag  = 1'b0;
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_wb_daq_data_disaggregation.sv
// Scoreboard bench for wb_daq_data_disaggregation: FIFO model feeds words, monitor pops expected slices.
module tb_wb_daq_data_disaggregation;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  data_width = 2'd0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_pop;
  logic [31:0] dac_data_out;
  logic        dac_valid;
  logic        dac_ready = 1'b0;
  logic        busy;
  logic        underrun_clr = 1'b0;
  logic        underrun_flag;
  logic [15:0] underrun_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_pops = 0;
  int n_xfers = 0;
  logic pop_seen = 1'b0;

  logic [31:0] fifo_mem[$];
  logic [31:0] exp_q[$];
  int          xfer_cyc[$];
  int          pop_cyc[$];

  wb_daq_data_disaggregation dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .data_width(data_width),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .dac_data_out(dac_data_out), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .busy(busy), .underrun_clr(underrun_clr), .underrun_flag(underrun_flag),
    .underrun_count(underrun_count)
  );

  always #5 wb_clk = ~wb_clk;
  always @(posedge wb_clk) cyc++;

  // FIFO model: read data appears the cycle after a pop; empty flag tracks the queue
  always @(posedge wb_clk) begin
    #1;
    if (pop_seen) begin
      if (fifo_mem.size() != 0) fifo_data = fifo_mem.pop_front();
    end
    fifo_empty = (fifo_mem.size() == 0);
  end

  // Monitor: inputs are stable at the falling edge, so this sees what the next rising edge captures
  always @(negedge wb_clk) begin
    logic [31:0] e;
    pop_seen = fifo_pop;
    if (fifo_pop) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL pop_on_empty got fifo_pop=1 with fifo_empty=1 required no pop");
      end
    end
    if (dac_valid && dac_ready) begin
      n_xfers++;
      xfer_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample got=%h required none", dac_data_out);
      end else begin
        e = exp_q.pop_front();
        if (dac_data_out !== e) begin
          errors++;
          $display("FAIL sample got=%h required=%h", dac_data_out, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk);
    #2;
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 30; i++) begin
      if (dac_valid) break;
      tick(1);
    end
    if (i == 30) begin
      checks++; errors++;
      $display("FAIL wait_valid timeout got dac_valid=0 required 1");
    end
  endtask

  task automatic drain();
    int i;
    tick(2);
    for (i = 0; i < 200; i++) begin
      if (!busy && fifo_mem.size() == 0 && fifo_empty && !pop_seen) break;
      tick(1);
    end
    if (i == 200) begin
      checks++; errors++;
      $display("FAIL drain timeout got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    #3;
    checks += 5;
    if (dac_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b required=0", dac_valid); end
    if (fifo_pop !== 1'b0)  begin errors++; $display("FAIL rst_pop got=%b required=0", fifo_pop); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (dac_data_out !== 32'h0) begin errors++; $display("FAIL rst_data got=%h required=0", dac_data_out); end
    if (underrun_flag !== 1'b0 || underrun_count !== 16'h0) begin
      errors++; $display("FAIL rst_underrun got=%b/%h required 0/0", underrun_flag, underrun_count);
    end
    tick(2);
    wb_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_8bit();
    int p0, x0;
    p0 = n_pops; x0 = n_xfers;
    xfer_cyc.delete(); pop_cyc.delete();
    enable = 1'b1; data_width = 2'd0; dac_ready = 1'b1;
    fifo_mem.push_back(32'hDDCCBBAA);
    exp_q.push_back(32'hAA); exp_q.push_back(32'hBB);
    exp_q.push_back(32'hCC); exp_q.push_back(32'hDD);
    drain();
    checks += 3;
    if (n_pops - p0 != 1) begin errors++; $display("FAIL b8_pops got=%0d required=1", n_pops - p0); end
    if (n_xfers - x0 != 4) begin errors++; $display("FAIL b8_xfers got=%0d required=4", n_xfers - x0); end
    else if (xfer_cyc[3] - xfer_cyc[0] != 3) begin
      errors++; $display("FAIL b8_consecutive got span=%0d required=3", xfer_cyc[3] - xfer_cyc[0]);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL b8_idle got busy=%b required=0", busy); end
  endtask

  task automatic test_back_to_back();
    int p0, x0;
    p0 = n_pops; x0 = n_xfers;
    xfer_cyc.delete(); pop_cyc.delete();
    data_width = 2'd1; dac_ready = 1'b1;
    fifo_mem.push_back(32'h44443333); fifo_mem.push_back(32'h22221111);
    exp_q.push_back(32'h3333); exp_q.push_back(32'h4444);
    exp_q.push_back(32'h1111); exp_q.push_back(32'h2222);
    drain();
    checks += 2;
    if (n_pops - p0 != 2) begin errors++; $display("FAIL b2b_pops got=%0d required=2", n_pops - p0); end
    if (n_xfers - x0 != 4) begin errors++; $display("FAIL b2b_xfers got=%0d required=4", n_xfers - x0); end
    else if (pop_cyc.size() == 2) begin
      checks += 3;
      if (xfer_cyc[0] - pop_cyc[0] != 2) begin
        errors++; $display("FAIL b2b_latency got=%0d required=2", xfer_cyc[0] - pop_cyc[0]);
      end
      if (pop_cyc[1] != xfer_cyc[1]) begin
        errors++; $display("FAIL b2b_pop_with_last got pop@%0d required @%0d", pop_cyc[1], xfer_cyc[1]);
      end
      if (xfer_cyc[2] - xfer_cyc[1] != 2) begin
        errors++; $display("FAIL b2b_bubble got gap=%0d required=2", xfer_cyc[2] - xfer_cyc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int x0;
    x0 = n_xfers;
    data_width = 2'd2; dac_ready = 1'b0;
    fifo_mem.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dac_valid !== 1'b1 || dac_data_out !== 32'h12345678) begin
        errors++; $display("FAIL bp_hold got valid=%b data=%h required 1/12345678", dac_valid, dac_data_out);
      end
      tick(1);
    end
    dac_ready = 1'b1;
    drain();
    checks++;
    if (n_xfers - x0 != 1) begin errors++; $display("FAIL bp_xfers got=%0d required=1", n_xfers - x0); end
  endtask

  task automatic test_width_change();
    int x0;
    x0 = n_xfers;
    data_width = 2'd0; dac_ready = 1'b1;
    fifo_mem.push_back(32'h44332211);
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    wait_valid();
    tick(1);
    data_width = 2'd2;
    drain();
    checks++;
    if (n_xfers - x0 != 4) begin errors++; $display("FAIL wchg_xfers got=%0d required=4", n_xfers - x0); end
    data_width = 2'd0;
  endtask

  task automatic test_enable_drop();
    int p0, i;
    p0 = n_pops;
    data_width = 2'd0; dac_ready = 1'b1;
    fifo_mem.push_back(32'h88776655); fifo_mem.push_back(32'hCCBBAA99);
    exp_q.push_back(32'h55); exp_q.push_back(32'h66);
    exp_q.push_back(32'h77); exp_q.push_back(32'h88);
    wait_valid();
    tick(1);
    enable = 1'b0;
    for (i = 0; i < 30; i++) begin
      if (!busy) break;
      tick(1);
    end
    tick(5);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL endrop_idle got busy=%b required=0", busy); end
    if (n_pops - p0 != 1) begin errors++; $display("FAIL endrop_pops got=%0d required=1", n_pops - p0); end
    if (fifo_mem.size() != 1) begin errors++; $display("FAIL endrop_fifo got=%0d required=1", fifo_mem.size()); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL endrop_drain got left=%0d required=0", exp_q.size()); end
    exp_q.push_back(32'h99); exp_q.push_back(32'hAA);
    exp_q.push_back(32'hBB); exp_q.push_back(32'hCC);
    enable = 1'b1;
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL endrop_resume got left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    int p0;
    p0 = n_pops;
    data_width = 2'd0; dac_ready = 1'b1;
    fifo_mem.push_back(32'h04030201); fifo_mem.push_back(32'h08070605);
    exp_q.push_back(32'h01);
    wait_valid();
    tick(1);
    #1 wb_rst = 1'b0;
    #1;
    checks += 3;
    if (dac_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b required=0", dac_valid); end
    if (fifo_pop !== 1'b0)  begin errors++; $display("FAIL arst_pop got=%b required=0", fifo_pop); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL arst_busy got=%b required=0", busy); end
    tick(2);
    @(negedge wb_clk);
    exp_q.push_back(32'h05); exp_q.push_back(32'h06);
    exp_q.push_back(32'h07); exp_q.push_back(32'h08);
    wb_rst = 1'b1;
    drain();
    checks += 2;
    if (n_pops - p0 != 2) begin errors++; $display("FAIL arst_pops got=%0d required=2", n_pops - p0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL arst_restart got left=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_underrun();
`ifdef WB_DAQ_DISAGG_UNDERRUN_EN
    underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
    checks++;
    if (underrun_flag !== 1'b0 || underrun_count !== 16'h0) begin
      errors++; $display("FAIL ur_preclr got=%b/%h required 0/0", underrun_flag, underrun_count);
    end
    enable = 1'b1; data_width = 2'd2; dac_ready = 1'b0;
    fifo_mem.push_back(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    wait_valid();
    dac_ready = 1'b1;
    tick(1);
    tick(10);
    dac_ready = 1'b0;
    tick(1);
    checks += 2;
    if (underrun_flag !== 1'b1) begin errors++; $display("FAIL ur_flag got=%b required=1", underrun_flag); end
    if (underrun_count !== 16'd10) begin errors++; $display("FAIL ur_count got=%0d required=10", underrun_count); end
    underrun_clr = 1'b1; dac_ready = 1'b1;
    tick(1);
    underrun_clr = 1'b0; dac_ready = 1'b0;
    tick(1);
    checks += 2;
    if (underrun_flag !== 1'b0) begin errors++; $display("FAIL ur_clr_flag got=%b required=0", underrun_flag); end
    if (underrun_count !== 16'd0) begin errors++; $display("FAIL ur_clr_count got=%0d required=0", underrun_count); end
`else
    dac_ready = 1'b1; underrun_clr = 1'b0;
    tick(5);
    checks++;
    if (underrun_flag !== 1'b0 || underrun_count !== 16'h0) begin
      errors++; $display("FAIL ur_tied got=%b/%h required 0/0", underrun_flag, underrun_count);
    end
    dac_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_8bit();
    test_back_to_back();
    test_backpressure();
    test_width_change();
    test_enable_drop();
    test_async_reset();
    test_underrun();
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
